// File: rtl/button_mmio_port_pkg.sv
// Shared constants for the memory-mapped push-button port: addresses,
// button indices and the default debounce period.
package button_mmio_port_pkg;

  localparam int NUM_BTN                 = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

  localparam logic [31:0] ADDR_C      = 32'd1000;
  localparam logic [31:0] ADDR_L      = 32'd3000;
  localparam logic [31:0] ADDR_R      = 32'd4000;
  localparam logic [31:0] ADDR_U      = 32'd5000;
  localparam logic [31:0] ADDR_D      = 32'd6000;
  localparam logic [31:0] ADDR_STATUS = 32'd7000;

  // Event address of button index idx.
  function automatic logic [31:0] btn_addr(input int idx);
    logic [31:0] a;
    case (idx)
      BTN_C:   a = ADDR_C;
      BTN_L:   a = ADDR_L;
      BTN_R:   a = ADDR_R;
      BTN_U:   a = ADDR_U;
      default: a = ADDR_D;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit synchronizer plus debounce counter producing a stable level.
module btn_debounce
  import button_mmio_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      // Any cycle agreeing with the stable level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_mmio_port.sv
// Debounced push-buttons exposed as sticky press events on a registered
// memory-mapped read port with a write-1-to-clear status register.
module button_mmio_port
  import button_mmio_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  btn_raw,
  input  logic [31:0] addr,
  input  logic        wren,
  input  logic [31:0] wdata,
  input  logic        rd_strobe,
  output logic [31:0] rdata,
  output logic        hit,
  output logic [4:0]  btn_level
);

  logic [4:0]  level_q;
  logic [4:0]  pending;
  logic [4:0]  rise;
  logic [4:0]  clr;
  logic [4:0]  rd_sel;
  logic        status_sel;
  logic        is_load;
  logic [31:0] load_data;
  logic        load_hit;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock (clock),
      .reset (reset),
      .pin   (btn_raw[g]),
      .level (btn_level[g])
    );
  end

  assign rise = btn_level & ~level_q;

  // rd_strobe together with wren is a store, never a load.
  always_comb begin
    is_load    = rd_strobe & ~wren;
    status_sel = (addr == ADDR_STATUS);
    rd_sel     = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rd_sel[i] = (addr == btn_addr(i));
    end
    clr = '0;
    if (is_load) clr = rd_sel;
    if (wren && status_sel) clr = wdata[4:0];
    load_data = '0;
    load_hit  = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (rd_sel[i]) begin
        load_data = {31'b0, pending[i]};
        load_hit  = 1'b1;
      end
    end
    if (status_sel) begin
      load_data = {11'b0, btn_level, 11'b0, pending};
      load_hit  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      pending <= '0;
      rdata   <= '0;
      hit     <= 1'b0;
    end else begin
      level_q <= btn_level;
      // A press arriving with a clear is kept so no event is lost.
      pending <= (pending & ~clr) | rise;
      if (is_load) begin
        rdata <= load_data;
        hit   <= load_hit;
      end
    end
  end

endmodule

// File: tb/tb_button_mmio_port.sv
// Bench for button_mmio_port with a short debounce period: directed press,
// glitch, W1C, set-beats-clear and reset-mid-debounce sequences.
module tb_button_mmio_port;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  btn_raw;
  logic [31:0] addr;
  logic        wren;
  logic [31:0] wdata;
  logic        rd_strobe;
  logic [31:0] rdata;
  logic        hit;
  logic [4:0]  btn_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    string       name;
  } vec_t;

  vec_t vecs[$];

  button_mmio_port #(.DEBOUNCE_CYCLES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .addr      (addr),
    .wren      (wren),
    .wdata     (wdata),
    .rd_strobe (rd_strobe),
    .rdata     (rdata),
    .hit       (hit),
    .btn_level (btn_level)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cmp(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out();
    logic [32:0] e;
    string       nm;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got none expected entry");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, {hit, rdata}, e);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] er, input logic eh,
                         input string nm);
    addr      = a;
    wren      = 1'b0;
    rd_strobe = 1'b1;
    exp_q.push_back({eh, er});
    name_q.push_back(nm);
    step();
    rd_strobe = 1'b0;
    check_out();
  endtask

  task automatic apply_vec(input vec_t v);
    addr      = v.addr;
    rd_strobe = v.rd;
    wren      = v.wr;
    wdata     = v.wdata;
    if (v.chk) begin
      exp_q.push_back({v.exp_hit, v.exp_rdata});
      name_q.push_back(v.name);
    end
    step();
    rd_strobe = 1'b0;
    wren      = 1'b0;
    wdata     = '0;
    if (v.chk) check_out();
  endtask

  initial begin
    reset     = 1'b1;
    btn_raw   = '0;
    addr      = '0;
    wren      = 1'b0;
    wdata     = '0;
    rd_strobe = 1'b0;

    // Table exercised with R and D held and their presses pending.
    vecs.push_back('{32'd7000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0014_0014, 1'b1, "rd_status_rd"});
    vecs.push_back('{32'd4000, 1'b1, 1'b1, 32'h1, 1'b0, 32'h0,         1'b0, "store_btn_addr"});
    vecs.push_back('{32'd7000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0014_0014, 1'b1, "status_after_btn_store"});
    vecs.push_back('{32'd7000, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0,         1'b0, "w1c_r"});
    vecs.push_back('{32'd7000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0014_0010, 1'b1, "status_after_w1c"});
    vecs.push_back('{32'd4000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,         1'b1, "load_r_cleared"});
    vecs.push_back('{32'd6000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1,         1'b1, "load_d_first"});
    vecs.push_back('{32'd6000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,         1'b1, "load_d_second"});
    vecs.push_back('{32'd7000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0014_0000, 1'b1, "status_all_clear"});
    vecs.push_back('{32'd2000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,         1'b0, "load_unmapped"});
    vecs.push_back('{32'd1000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,         1'b1, "load_c_none"});

    step(2);
    cmp("reset_rdata_hit", {hit, rdata}, 33'h0);
    cmp("reset_level", {28'h0, btn_level}, 33'h0);
    reset = 1'b0;

    // Idle buttons.
    step(20);
    cmp("idle_level", {28'h0, btn_level}, 33'h0);
    do_load(32'd7000, 32'h0, 1'b1, "idle_status");

    // Press L: level rises 6 cycles after the pin.
    btn_raw = 5'b00010;
    step(5);
    cmp("l_level_early", {28'h0, btn_level}, 33'h0);
    step();
    cmp("l_level_rise", {28'h0, btn_level}, {28'h0, 5'b00010});
    step(3);
    do_load(32'd3000, 32'h1, 1'b1, "load_l_first");
    do_load(32'd3000, 32'h0, 1'b1, "load_l_second");
    btn_raw = '0;
    step(10);
    cmp("l_release", {28'h0, btn_level}, 33'h0);

    // Glitches of 3 cycles on C never reach the stable level.
    for (int p = 0; p < 2; p++) begin
      btn_raw = 5'b00001;
      for (int k = 0; k < 3; k++) begin
        step();
        cmp("glitch_level_hi", {28'h0, btn_level}, 33'h0);
      end
      btn_raw = '0;
      for (int k = 0; k < 3; k++) begin
        step();
        cmp("glitch_level_lo", {28'h0, btn_level}, 33'h0);
      end
    end
    step(6);
    do_load(32'd1000, 32'h0, 1'b1, "glitch_load_c");
    do_load(32'd7000, 32'h0, 1'b1, "glitch_status");

    // R and D held, then the vector table.
    btn_raw = 5'b10100;
    step(10);
    foreach (vecs[i]) apply_vec(vecs[i]);
    btn_raw = '0;
    step(10);

    // U press edge lands on the same edge as a load of U.
    btn_raw = 5'b01000;
    step(6);
    cmp("u_level_rise", {28'h0, btn_level}, {28'h0, 5'b01000});
    do_load(32'd5000, 32'h0, 1'b1, "u_coincide_old");
    do_load(32'd5000, 32'h1, 1'b1, "u_set_wins");
    exp_q.push_back({1'b1, 32'h1});
    name_q.push_back("u_hold");
    step(2);
    check_out();
    btn_raw = '0;
    step(10);

    // Reset in the middle of a C debounce, C held through release.
    btn_raw = 5'b00001;
    step(4);
    reset = 1'b1;
    #1;
    cmp("midreset_outputs", {hit, rdata}, 33'h0);
    cmp("midreset_level", {28'h0, btn_level}, 33'h0);
    step(2);
    reset = 1'b0;
    step(5);
    cmp("c_level_early", {28'h0, btn_level}, 33'h0);
    step();
    cmp("c_level_rise", {28'h0, btn_level}, 33'h1);
    do_load(32'd7000, 32'h0001_0000, 1'b1, "c_pending_edge7_pre");
    do_load(32'd7000, 32'h0001_0001, 1'b1, "c_pending_set");
    do_load(32'd8000, 32'h0, 1'b0, "load_8000_miss");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_mmio_port.md
# button_mmio_port

Debounces the five board push-buttons, turns each clean press into a sticky pending event, and serves those events to the processor as memory-mapped load data. It sits between the raw button pins and the wrapper's data-memory read mux, in place of per-button level taps. The block supplies the VGA controller with clean button levels. The processor sees one event per press and no repeats, however long its polling loop takes.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); must be ≥2
- ADDR_C / ADDR_L / ADDR_R / ADDR_U / ADDR_D, 1000 / 3000 / 4000 / 5000 / 6000, per-button event addresses
- ADDR_STATUS, 7000, all-button status / write-1-to-clear address

Ports:
- clock  in  1  system clock; one clock, all state on its rising edge
- reset  in  1  asynchronous, active-high
- btn_raw  in  5  raw pins {D,U,R,L,C}, bit0=C, bit1=L, bit2=R, bit3=U, bit4=D
- addr  in  32  processor data address
- wren  in  1  processor store enable
- wdata  in  32  processor store data
- rd_strobe  in  1  one-cycle pulse marking the cycle a load's address is valid
- rdata  out  32  registered load data
- hit  out  1  registered; a load in the previous cycle matched one of this block's addresses (drives the wrapper mux select)
- btn_level  out  5  debounced button levels, to VGA controller

## Operation
- Per button: 2-flop synchronizer → debounce counter → stable level → rising-edge detect → pending flag.
- Debounce:
  - The counter resets to 0 whenever the synchronized input equals the stable level.
  - Otherwise it increments.
  - On reaching DEBOUNCE_CYCLES−1, the stable level takes the synchronized value and the counter clears.
- Press event: a 0→1 transition of the stable level sets pending[i]. A release does not affect pending.
- Load from a per-button address, with rd_strobe=1 and wren=0:
  - rdata ← {31'b0, pending[i]}.
  - pending[i] clears at the same edge.
- Load from ADDR_STATUS: rdata ← {11'b0, btn_level, 11'b0, pending}. Pending is not cleared.
- Store to ADDR_STATUS, with wren=1: pending &= ~wdata[4:0]. Stores to the per-button addresses are ignored.
- A load whose address matches none of this block's addresses gives rdata=0 and hit=0.
- Set and clear in the same cycle, by load or by W1C: set wins, so the pending bit stays 1 and no press is lost.
- Multiple presses before a read collapse into one pending event.
- rd_strobe with wren=1 is treated as a store.

## Timing
- Reset values: rdata=0, hit=0, btn_level=0, pending=0, counters=0, synchronizers=0.
- Reset asserted mid-debounce discards the partial count. A button held through reset release registers as a press after the full debounce period.
- Pin-to-btn_level latency: 2 (sync) + DEBOUNCE_CYCLES cycles.
- Pending is set 1 cycle after btn_level rises.
- rdata and hit are valid in the cycle after rd_strobe, matching the RAM's read latency. Both hold their value until the next rd_strobe.
- A pending clear from a read is visible in the status register on the next cycle.
- Glitches shorter than DEBOUNCE_CYCLES leave btn_level unchanged.

## Structure
- Shared package holds:
  - the address constants
  - the button index constants BTN_C=0, BTN_L=1, BTN_R=2, BTN_U=3, BTN_D=4
  - the default DEBOUNCE_CYCLES
- One sub-module, btn_debounce, covers synchronizer, counter and stable level for 1 bit. It is instantiated 5× with DEBOUNCE_CYCLES passed through.
- The top level holds edge detect, the pending register, address decode and the registered read port.
- The counter width is $clog2(DEBOUNCE_CYCLES).

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then hold all buttons low for 20 cycles → btn_level=0, a status read gives rdata=0, hit=1.
- Press L (btn_raw=5'b00010) held for 10 cycles → btn_level[1] rises 6 cycles after the pin. A load at 3000 gives rdata=1. A second load at 3000 gives rdata=0.
- 3-cycle glitch on C, with high pulses separated by lows → btn_level and pending stay 0. A load at 1000 gives rdata=0.
- Press R and D, then load 7000 → rdata=32'h0014_0014 with buttons held. Store 32'h4 to 7000, then load 7000 → pending=5'b10000.
- A new U press edge coincides with a load at 5000 → that load returns the old value (0). The next load at 5000 returns 1, because set beats clear.
- Assert reset 2 cycles into a C press debounce, then release reset with C held → pending[0] sets 7 cycles after reset release. Load address 8000 → hit=0, rdata=0.
